// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and sequencer state encoding for the register file slice
package regfile_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - two-read one-write register file, reg[i]=i after reset
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_address1,
  input  logic [ADDR_W-1:0] read_address2,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array: identity contents on reset, single write port on the rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(i);
      end
    end else if (write_enable) begin
      mem[write_address] <= write_data;
    end
  end

  assign out_data1 = mem[read_address1];
  assign out_data2 = mem[read_address2];

endmodule

// File: rtl/regfile_access_sequencer.sv
// rtl/regfile_access_sequencer.sv - serialises upstream read/write requests onto register-file ports
module regfile_access_sequencer
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddrA,
  input  logic [ADDR_W-1:0] ReqAddrB,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspDataA,
  output logic [DATA_W-1:0] RspDataB,
  output logic [ADDR_W-1:0] RfReadAddress1,
  output logic [ADDR_W-1:0] RfReadAddress2,
  output logic [ADDR_W-1:0] RfWriteAddress,
  output logic [DATA_W-1:0] RfWriteData,
  output logic              RfWriteEnable,
  input  logic [DATA_W-1:0] RfOutData1,
  input  logic [DATA_W-1:0] RfOutData2,
  output logic [7:0]        OpCount
);

  seq_state_t        state;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata;

  // Ready is combinational so the very first edge after reset release can accept
  assign ReqReady = (state == IDLE) && RST_N;

  // Register-file address/data come straight from the request latches
  assign RfReadAddress1 = addr_a;
  assign RfReadAddress2 = addr_b;
  assign RfWriteAddress = addr_a;
  assign RfWriteData    = wdata;

  // Sequencer FSM with registered outputs; reset aborts any in-flight operation
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      addr_a        <= '0;
      addr_b        <= '0;
      wdata         <= '0;
      RfWriteEnable <= 1'b0;
      RspValid      <= 1'b0;
      RspDataA      <= '0;
      RspDataB      <= '0;
      OpCount       <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            addr_a <= ReqAddrA;
            if (ReqWrite) begin
              wdata         <= ReqData;
              RfWriteEnable <= 1'b1;
              state         <= WRITE;
            end else begin
              addr_b <= ReqAddrB;
              state  <= READ;
            end
          end
        end
        WRITE: begin
          // The register file commits at the edge that closes this cycle
          RfWriteEnable <= 1'b0;
          OpCount       <= OpCount + 8'd1;
          state         <= IDLE;
        end
        READ: begin
          RspDataA <= RfOutData1;
          RspDataB <= RfOutData2;
          RspValid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            OpCount  <= OpCount + 8'd1;
            state    <= IDLE;
          end
        end
        default: begin
          RfWriteEnable <= 1'b0;
          RspValid      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_access_sequencer.md
REGFILE_ACCESS_SEQUENCER -- requirements
Module: regfile_access_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register word width.
REQ-002 SHALL have parameter ADDR_W, default 4: register address width.
REQ-003 SHALL have port CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ReqValid  in  1  upstream request valid.
REQ-006 SHALL have port ReqReady  out  1  request accepted when ReqValid&&ReqReady at an edge.
REQ-007 SHALL have port ReqWrite  in  1  1=write ReqAddrA, 0=read ReqAddrA and ReqAddrB.
REQ-008 SHALL have ports ReqAddrA, ReqAddrB  in  ADDR_W  request addresses.
REQ-009 SHALL have port ReqData  in  DATA_W  write data.
REQ-010 SHALL have ports RspValid  out  1 and RspReady  in  1: read-response handshake.
REQ-011 SHALL have ports RspDataA, RspDataB  out  DATA_W  read results for AddrA and AddrB.
REQ-012 SHALL have ports RfReadAddress1, RfReadAddress2, RfWriteAddress  out  ADDR_W; RfWriteData  out  DATA_W; RfWriteEnable  out  1: drive register-file ports.
REQ-013 SHALL have ports RfOutData1, RfOutData2  in  DATA_W  combinational register-file read data.
REQ-014 SHALL have port OpCount  out  8  completed-operation counter.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, READ, RESP.
REQ-016 ReqReady SHALL be 1 only in IDLE with RST_N high; requests at other times are not accepted.
REQ-017 IDLE: accepted write -> latch ReqAddrA/ReqData, go WRITE; accepted read -> latch ReqAddrA/ReqAddrB, go READ.
REQ-018 WRITE: RfWriteEnable=1 for exactly one cycle with RfWriteAddress/RfWriteData from latches; register file commits at that cycle's closing edge; next IDLE.
REQ-019 RfWriteEnable SHALL be 0 in every state other than WRITE.
REQ-020 RfReadAddress1/2 SHALL be driven from latched addresses in all states, stable through READ.
REQ-021 READ: at the closing edge, RfOutData1/2 captured into RspDataA/B; next RESP.
REQ-022 RESP: RspValid=1, RspDataA/B held stable until RspValid&&RspReady at an edge, then IDLE.
REQ-023 Latency: write enable asserted the cycle after accept; RspValid asserted 2 cycles after accept edge; best-case throughput 1 write per 2 cycles, 1 read per 3 cycles.
REQ-024 A read accepted after a write to the same address SHALL return the newly written value.
REQ-025 ReqAddrA==ReqAddrB SHALL return identical data on both outputs.
REQ-026 RspReady outside RESP SHALL have no effect.
REQ-027 OpCount SHALL increment by 1 in WRITE and on each response handshake, wrapping 255->0 modulo 2^8.

Reset
REQ-028 RST_N low SHALL asynchronously force IDLE, ReqReady=0, RspValid=0, RfWriteEnable=0, RspDataA/B=0, latched addresses/data=0, OpCount=0.
REQ-029 Reset mid-operation SHALL abort it; a pending write is not committed; a pending response is discarded.
REQ-030 First request is accepted at the first edge after RST_N rises with ReqValid=1.

Structure
REQ-031 DATA_W/ADDR_W defaults and FSM state encodings SHALL reside in shared package/header regfile_pkg, also used by the register file.
REQ-032 No sub-module SHALL be required; the bench instantiates the register file (8-bit, reg[i]=i initialised) as the responder.

Verification
REQ-033 Write A=3 D=0xA5 -> next cycle RfWriteEnable=1, RfWriteAddress=3, RfWriteData=0xA5, single cycle; OpCount=1.
REQ-034 Write A=3 D=0xA5 then read A=3 B=5 -> RspDataA=0xA5, RspDataB=0x05, RspValid 2 cycles after read accept.
REQ-035 Read A=2 B=9 with RspReady low 5 cycles -> RspValid held, data 0x02/0x09 stable, ReqReady=0, concurrent ReqValid ignored.
REQ-036 Read A=B=7 -> RspDataA=RspDataB=0x07.
REQ-037 RST_N low during WRITE cycle -> RfWriteEnable falls immediately, target register unchanged, OpCount=0, ReqReady=1 after release.
REQ-038 256 completed operations from reset -> OpCount returns to 0.
